// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code set 2 definitions: decoder states, protocol byte
// constants, the 16-bit key-event word layout and small decode helpers.
package ps2_pkg;

  localparam int unsigned KEY_W  = 16;
  localparam int unsigned SKIP_W = 3;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;

  // Non-key bytes seen in IDLE: ack, BAT ok, echo, resend, error codes
  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_BAT     = 8'hAA;
  localparam logic [7:0] PS2_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_ERR0    = 8'h00;
  localparam logic [7:0] PS2_ERR1    = 8'hFF;

  // Pause is E1 followed by seven more bytes
  localparam logic [SKIP_W-1:0] PS2_PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE
  } ps2_dec_state_t;

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [5:0] rsvd;
    logic [7:0] code;
  } key_event_t;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

  function automatic key_event_t mk_event(input logic rel, input logic ext,
                                          input logic [7:0] code);
    key_event_t ev;
    ev.rel  = rel;
    ev.ext  = ext;
    ev.rsvd = 6'b0;
    ev.code = code;
    return ev;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head word.
// Ports: clk/rst_n (sync active-low), push_i/data_i write side,
// pop_i read side (ignored when empty), head_o (zero when empty),
// valid_o non-empty, count_o entries stored. A push while full only
// succeeds if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt_c;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q;
  logic             full_c, empty_c, pop_ok_c, push_ok_c;

  // Push/pop qualification and next head word
  always_comb begin
    full_c    = (count_q == CW'(DEPTH));
    empty_c   = (count_q == '0);
    pop_ok_c  = pop_i & ~empty_c;
    push_ok_c = push_i & (~full_c | pop_ok_c);
    count_d   = count_q + CW'(push_ok_c) - CW'(pop_ok_c);
    rd_nxt_c  = rd_ptr_q + AW'(1);
    head_d    = head_q;
    if (pop_ok_c) begin
      if (count_d == '0)
        head_d = '0;
      else if (count_q == CW'(1))
        head_d = data_i;          // next entry is the one being written now
      else
        head_d = mem_q[rd_nxt_c];
    end else if (push_ok_c && empty_c) begin
      head_d = data_i;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers, occupancy and head register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_ok_c);
      rd_ptr_q <= rd_ptr_q + AW'(pop_ok_c);
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
    end
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/ps2_key_fifo.sv
// PS/2 scan-code set 2 decoder feeding a FWFT key-event FIFO for the CPU.
// Ports: clk50, rst_n (sync active-low); rx_data/rx_en byte stream from the
// PS/2 controller; rd_req pops the head event; clr_ovf clears the sticky
// overflow flag. key_word/key_valid present the head event, count the
// occupancy, overflow flags dropped events, dec_busy marks a partial sequence.
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk50,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_en,
  input  logic                   rd_req,
  input  logic                   clr_ovf,
  output logic [15:0]            key_word,
  output logic                   key_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   dec_busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ps2_dec_state_t     state_q, state_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;
  logic               ovf_q, busy_q;
  logic               emit_c, drop_c, full_c;
  key_event_t         event_c;
  logic [KEY_W-1:0]   head_w;
  logic [CW-1:0]      count_w;

  // Byte decode: the event is pushed in the same cycle as its final byte
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit_c  = 1'b0;
    event_c = '0;
    if (rx_en) begin
      case (state_q)
        IDLE: begin
          if (rx_data == PS2_EXT) begin
            state_d = EXT;
          end else if (rx_data == PS2_BRK) begin
            state_d = BRK;
          end else if (rx_data == PS2_PAUSE) begin
            state_d = PAUSE;
            skip_d  = PS2_PAUSE_SKIP;
          end else if (!is_discard(rx_data)) begin
            emit_c  = 1'b1;
            event_c = mk_event(1'b0, 1'b0, rx_data);
          end
        end
        EXT: begin
          if (rx_data == PS2_BRK) begin
            state_d = EXT_BRK;
          end else begin
            state_d = IDLE;
            // repeated prefixes are malformed; E0 12 is a fake shift
            if (rx_data != PS2_EXT && rx_data != PS2_PAUSE &&
                rx_data != PS2_FAKE_SHIFT) begin
              emit_c  = 1'b1;
              event_c = mk_event(1'b0, 1'b1, rx_data);
            end
          end
        end
        BRK: begin
          state_d = IDLE;
          emit_c  = 1'b1;
          event_c = mk_event(1'b1, 1'b0, rx_data);
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (rx_data != PS2_FAKE_SHIFT) begin
            emit_c  = 1'b1;
            event_c = mk_event(1'b1, 1'b1, rx_data);
          end
        end
        PAUSE: begin
          skip_d = skip_q - SKIP_W'(1);
          if (skip_q <= SKIP_W'(1)) begin
            state_d = IDLE;
            skip_d  = '0;
            emit_c  = 1'b1;
            event_c = mk_event(1'b0, 1'b1, PS2_PAUSE_CODE);
          end
        end
        default: begin
          state_d = IDLE;
          skip_d  = '0;
        end
      endcase
    end
  end

  // A full FIFO only drops the event when no pop frees a slot this cycle
  always_comb begin
    full_c = (count_w == CW'(DEPTH));
    drop_c = emit_c & full_c & ~rd_req;
  end

  // Decoder state, sticky overflow (set beats clear) and busy flag
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state_q <= IDLE;
      skip_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      ovf_q   <= drop_c | (ovf_q & ~clr_ovf);
      busy_q  <= (state_d != IDLE);
    end
  end

  sync_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk50),
    .rst_n   (rst_n),
    .push_i  (emit_c),
    .data_i  (event_c),
    .pop_i   (rd_req),
    .head_o  (head_w),
    .valid_o (key_valid),
    .count_o (count_w)
  );

  assign key_word = head_w;
  assign count    = count_w;
  assign overflow = ovf_q;
  assign dec_busy = busy_q;

endmodule

// File: doc/ps2_key_fifo.md
# ps2_key_fifo

Sits between `PS2_Controller` (raw byte stream) and the CPU keyboard port. It decodes PS/2 scan-code set 2 byte sequences (E0 extended prefix, F0 break prefix, E1 Pause sequence) into single 16-bit key-event words. It buffers those words in a first-word-fall-through FIFO that the CPU pops one word at a time. Runs entirely in the 50 MHz domain, so no CDC is needed between controller and CPU interface.

## Interface
- `DEPTH`, 16: FIFO depth in events; power of two, 2..256.
- `clk50`  in  1  50 MHz system clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `rx_data`  in  8  byte from `PS2_Controller.received_data`.
- `rx_en`  in  1  1-cycle strobe; `rx_data` valid this cycle.
- `rd_req`  in  1  pop head event this cycle (ignored when empty).
- `clr_ovf`  in  1  clear sticky overflow flag.
- `key_word`  out  16  head event: [15]=release, [14]=extended, [13:8]=0, [7:0]=make code; 16'h0000 when empty.
- `key_valid`  out  1  FIFO non-empty.
- `count`  out  $clog2(DEPTH)+1  events stored.
- `overflow`  out  1  sticky: at least one event dropped because the FIFO was full.
- `dec_busy`  out  1  decoder is mid-sequence (not in IDLE).

## Operation
- The decoder FSM advances only on cycles with `rx_en`=1.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE with skip counter = 7.
  - FA, AA, EE, FE, 00, FF (ack/BAT/echo/resend/error): discard, stay in IDLE.
  - Any other byte: emit {rel=0, ext=0, code}.
- EXT:
  - F0 -> EXT_BRK.
  - E0 or E1 -> discard, back to IDLE (malformed sequence).
  - 12 (fake shift): discard, -> IDLE.
  - Otherwise: emit {0,1,code}, -> IDLE.
- BRK: any byte -> emit {1,0,code}, -> IDLE.
- EXT_BRK:
  - 12: discard, -> IDLE.
  - Otherwise: emit {1,1,code}, -> IDLE.
- PAUSE:
  - Each byte decrements the skip counter.
  - On the byte that takes it to 0: emit {0,1,8'h77}, -> IDLE.
  - No release event is ever generated for Pause.
- Emit is a push into the FIFO:
  - Full, no pop this cycle: event dropped, `overflow` set; FIFO contents unchanged.
  - Full with `rd_req` the same cycle: push and pop both occur, `count` unchanged, no overflow.
  - Empty with `rd_req` the same cycle: pop ignored, push occurs.
- `rd_req` while empty: no effect, no error.
- `clr_ovf` and a new overflow in the same cycle: `overflow` stays 1 (set wins).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is maintained separately; full when `count`==DEPTH.
- Reset values (rst_n=0 at a rising edge):
  - FSM = IDLE; skip counter = 0; pointers and `count` = 0.
  - Outputs: `overflow`=0, `key_valid`=0, `key_word`=0, `dec_busy`=0.
  - RAM contents don't care.
  - A reset mid-sequence abandons the partial sequence; the next byte is decoded from IDLE.

## Timing
- Final byte of a sequence on `rx_en` in cycle N -> event in FIFO; when previously empty, `key_valid`=1 and `key_word` valid in cycle N+1.
- `key_word` is registered, first-word-fall-through: valid whenever `key_valid`=1, with no read latency.
- `rd_req` in cycle N (non-empty) -> next entry (or empty state) visible in cycle N+1. Back-to-back pops every cycle are allowed.
- `count`, `overflow` and `dec_busy` are registered and update one cycle after the causing event.
- Consecutive `rx_en` strobes may arrive on adjacent cycles; the block must accept one byte per cycle with no stall.

## Structure
- Shared package `ps2_pkg`:
  - `ps2_dec_state_t` enum: IDLE, EXT, BRK, EXT_BRK, PAUSE.
  - Byte constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_FAKE_SHIFT=8'h12, PS2_PAUSE_CODE=8'h77, plus the discard list.
  - `key_event_t` packed struct {rel, ext, 6'b0, code}.
- One sub-module: `sync_fifo` (parameterised WIDTH/DEPTH, FWFT, registered head, full/empty/count). The decoder FSM stays in `ps2_key_fifo`.

## Test plan
- Bytes 1C; F0 1C -> two words 16'h001C then 16'h801C; `count` goes 1 then 2; popping both returns `key_valid`=0.
- E0 75; E0 F0 75; E0 12 -> 16'h4075, 16'hC075, and nothing for the fake shift; `dec_busy` high between prefix and code.
- E1 14 77 E1 F0 14 F0 77 -> exactly one word 16'h4077 after the 8th byte; bytes FA, AA in IDLE produce no events.
- 17 make codes with DEPTH=16 and no pops -> `count`=16, 17th dropped, `overflow`=1. Pop and push in the same cycle while full -> no further overflow. `clr_ovf` -> 0.
- Continuous push/pop interleave across 40 events -> FIFO order preserved across pointer wrap; `rd_req` when empty leaves `count`=0.
- `rst_n`=0 for one cycle after E0 F0 -> FIFO empty; a following 1C yields 16'h001C (not extended/release).
